wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Write-back stage and register file, driven by the MEM/WB pipeline register outputs.
//   Selects the write-back value (load data or ALU result) and commits it to an
//   8-entry register file on the clock edge. Serves two combinational read ports
//   to decode, with same-cycle write-to-read bypass.
//   Keeps a wrapping count of committed writes for performance and debug.
// PARAMETERS
//   DATA_W   32  register and write-back data width
//   ADDR_W   3   register address width; NREGS = 2**ADDR_W entries
//   ZERO_REG 1   1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary
//   CNT_W    16  width of retire_count
// PORTS
//   clk           in   1       clock; all state updates on the rising edge
//   rst           in   1       asynchronous, active-high reset
//   WB_regwrite   in   1       write enable from MEM/WB
//   WB_memtoreg   in   1       1: write WB_rdata; 0: write WB_out
//   WB_rdata      in   DATA_W  memory load data
//   WB_out        in   DATA_W  ALU result
//   WB_rd         in   ADDR_W  destination register
//   rs1_addr      in   ADDR_W  read port 1 address
//   rs2_addr      in   ADDR_W  read port 2 address
//   rs1_data      out  DATA_W  read port 1 data (combinational)
//   rs2_data      out  DATA_W  read port 2 data (combinational)
//   wb_data       out  DATA_W  selected write-back value, exported for forwarding
//   retire_count  out  CNT_W   number of committed writes
// BEHAVIOUR
//   - wb_data = WB_memtoreg ? WB_rdata : WB_out. Combinational; valid every cycle,
//     regardless of WB_regwrite.
//   - Commit: commit = WB_regwrite && !(ZERO_REG && WB_rd==0).
//     On a rising edge with commit=1, regs[WB_rd] <= wb_data.
//     Write latency is 1 edge. The write is visible in the array after that edge.
//   - Read portN: if ZERO_REG && addr==0, return 0.
//     Else if commit && addr==WB_rd, return wb_data (bypass, same cycle).
//     Else return regs[addr].
//   - Both ports may read the same address. Each is bypassed independently.
//   - retire_count increments by 1 on each edge where commit=1.
//     Wraps from 2**CNT_W-1 to 0 with no flag.
//     A suppressed write to r0 (ZERO_REG=1) does not count.
//   - X or undefined inputs while WB_regwrite=0 never alter state.
//   - Reset (async, any time, including mid-write):
//     all regs = 0, retire_count = 0, immediately.
//     A write on the edge coincident with rst asserted is discarded.
//     While rst=1, rs1_data/rs2_data read 0 unless bypassed; wb_data stays combinational.
//     First commit possible on the first rising edge after rst deasserts.
//   - No internal state machine beyond the array and counter.
//     No stall input: the upstream pipeline holds WB_* stable if it needs to stall.
// TESTING
//   1. Reset: assert rst mid-cycle with the array preloaded.
//      -> rs1_data=rs2_data=0 and retire_count=0 asynchronously, before the next edge.
//   2. ALU write: regwrite=1, memtoreg=0, out=0xDEADBEEF, rd=3, rs1_addr=3.
//      -> rs1_data=0xDEADBEEF in the same cycle (bypass).
//      -> After the edge with regwrite=0, still 0xDEADBEEF. retire_count=1.
//   3. Load write: memtoreg=1, rdata=0x12345678, out=0xFFFFFFFF, rd=5.
//      -> wb_data=0x12345678 and regs[5]=0x12345678.
//   4. r0 (ZERO_REG=1): write 0xAAAA5555 to rd=0.
//      -> rs1_addr=0 reads 0 and retire_count is unchanged.
//      -> Repeat with ZERO_REG=0: reads 0xAAAA5555 and the count increments.
//   5. Dual read / bypass priority: regs[2]=7, write 9 to rd=2, rs1=rs2=2.
//      -> Both ports read 9 in the write cycle.
//      -> With regwrite=0, both read 7 (no bypass).
//   6. Counter wrap (CNT_W=4): 17 consecutive commits -> retire_count=1.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register / decode stage and the write-back register file.
// The master drives the write-back fields and read addresses; the slave returns read data and status.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic              WB_regwrite;
    logic              WB_memtoreg;
    logic [DATA_W-1:0] WB_rdata;
    logic [DATA_W-1:0] WB_out;
    logic [ADDR_W-1:0] WB_rd;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  retire_count;

    modport master (
        output WB_regwrite, WB_memtoreg, WB_rdata, WB_out, WB_rd, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data, retire_count
    );

    modport slave (
        input  WB_regwrite, WB_memtoreg, WB_rdata, WB_out, WB_rd, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data, retire_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage plus register file: selects load/ALU data, commits it on the clock edge,
// serves two bypassed combinational read ports and counts committed writes.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input logic          clk,
    input logic          rst,
    wb_regfile_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] wb_sel;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [CNT_W-1:0]  retire_q;
    logic              zero_rd;
    logic              commit;

    always_comb begin
        wb_sel  = bus.WB_memtoreg ? bus.WB_rdata : bus.WB_out;
        zero_rd = (ZERO_REG != 0) && (bus.WB_rd == '0);
        commit  = bus.WB_regwrite && !zero_rd;
    end

    // Hardwired-zero check has priority over the same-cycle bypass.
    always_comb begin
        rd1 = regs[bus.rs1_addr];
        if (commit && (bus.rs1_addr == bus.WB_rd))
            rd1 = wb_sel;
        if ((ZERO_REG != 0) && (bus.rs1_addr == '0))
            rd1 = '0;

        rd2 = regs[bus.rs2_addr];
        if (commit && (bus.rs2_addr == bus.WB_rd))
            rd2 = wb_sel;
        if ((ZERO_REG != 0) && (bus.rs2_addr == '0))
            rd2 = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            retire_q <= '0;
        end else if (commit) begin
            regs[bus.WB_rd] <= wb_sel;
            retire_q        <= retire_q + CNT_W'(1);
        end
    end

    assign bus.wb_data      = wb_sel;
    assign bus.rs1_data     = rd1;
    assign bus.rs2_data     = rd2;
    assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: two instances (hardwired r0 / 16-bit count, ordinary r0 / 4-bit count)
// share one stimulus stream and are checked against an array-and-counter reference model.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(3), .CNT_W(16)) bz ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(3), .CNT_W(4))  bn ();

    wb_regfile #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .CNT_W(16)) dut_z (
        .clk(clk), .rst(rst), .bus(bz.slave)
    );
    wb_regfile #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .bus(bn.slave)
    );

    always #5 clk = ~clk;

    // Reference model: plain register contents and unbounded commit counts per instance.
    logic [31:0] mz [8];
    logic [31:0] mn [8];
    int          cz;
    int          cn;

    logic        cur_we;
    logic        cur_m2r;
    logic [31:0] cur_rdata;
    logic [31:0] cur_out;
    logic [2:0]  cur_rd;
    logic [2:0]  cur_a1;
    logic [2:0]  cur_a2;

    function automatic logic [31:0] expWb();
        return cur_m2r ? cur_rdata : cur_out;
    endfunction

    function automatic bit expCommit(bit zr);
        return cur_we && !(zr && cur_rd == 3'd0);
    endfunction

    function automatic logic [31:0] expRead(bit zr, logic [2:0] a);
        if (zr && a == 3'd0) return 32'd0;
        if (expCommit(zr) && a == cur_rd) return expWb();
        return zr ? mz[a] : mn[a];
    endfunction

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
            $error("[TB] %s check did not hold", tag);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 8; i++) begin
            mz[i] = 32'd0;
            mn[i] = 32'd0;
        end
        cz = 0;
        cn = 0;
    endtask

    task automatic applyStimulus(logic we, logic m2r, logic [31:0] rdata, logic [31:0] out,
                                 logic [2:0] rd, logic [2:0] a1, logic [2:0] a2);
        cur_we = we; cur_m2r = m2r; cur_rdata = rdata; cur_out = out;
        cur_rd = rd; cur_a1 = a1; cur_a2 = a2;
        bz.WB_regwrite = we; bz.WB_memtoreg = m2r; bz.WB_rdata = rdata; bz.WB_out = out;
        bz.WB_rd = rd; bz.rs1_addr = a1; bz.rs2_addr = a2;
        bn.WB_regwrite = we; bn.WB_memtoreg = m2r; bn.WB_rdata = rdata; bn.WB_out = out;
        bn.WB_rd = rd; bn.rs1_addr = a1; bn.rs2_addr = a2;
    endtask

    task automatic checkOutput();
        cmp("z_rs1", bz.rs1_data, expRead(1'b1, cur_a1));
        cmp("z_rs2", bz.rs2_data, expRead(1'b1, cur_a2));
        cmp("z_wb",  bz.wb_data,  expWb());
        cmp("z_cnt", 32'(bz.retire_count), 32'(cz % 65536));
        cmp("n_rs1", bn.rs1_data, expRead(1'b0, cur_a1));
        cmp("n_rs2", bn.rs2_data, expRead(1'b0, cur_a2));
        cmp("n_wb",  bn.wb_data,  expWb());
        cmp("n_cnt", 32'(bn.retire_count), 32'(cn % 16));
    endtask

    task automatic settle();
        #2;
        checkOutput();
    endtask

    // Advance through the rising edge (updating the model) to the following falling edge.
    task automatic nextCycle();
        @(posedge clk);
        if (!rst) begin
            if (expCommit(1'b1)) begin mz[cur_rd] = expWb(); cz++; end
            if (expCommit(1'b0)) begin mn[cur_rd] = expWb(); cn++; end
        end
        @(negedge clk);
    endtask

    initial begin
        clearModel();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd1, 3'd2);
        settle();
        cmp("reset_cnt", 32'(bz.retire_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU write with same-cycle bypass, then held value after the edge.
        applyStimulus(1'b1, 1'b0, 32'd0, 32'hDEADBEEF, 3'd3, 3'd3, 3'd0);
        settle();
        cmp("alu_bypass", bz.rs1_data, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd3, 3'd3, 3'd3);
        settle();
        cmp("alu_held", bz.rs1_data, 32'hDEADBEEF);
        cmp("alu_cnt", 32'(bz.retire_count), 32'd1);
        nextCycle();

        // Load write selects memory data.
        applyStimulus(1'b1, 1'b1, 32'h12345678, 32'hFFFFFFFF, 3'd5, 3'd5, 3'd3);
        settle();
        cmp("load_wb", bz.wb_data, 32'h12345678);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd5, 3'd5);
        settle();
        cmp("load_reg", bz.rs1_data, 32'h12345678);
        nextCycle();

        // r0: hardwired on dut_z, ordinary on dut_n.
        applyStimulus(1'b1, 1'b0, 32'd0, 32'hAAAA5555, 3'd0, 3'd0, 3'd0);
        settle();
        cmp("r0_z_bypass", bz.rs1_data, 32'd0);
        cmp("r0_n_bypass", bn.rs1_data, 32'hAAAA5555);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0);
        settle();
        cmp("r0_z_read", bz.rs1_data, 32'd0);
        cmp("r0_n_read", bn.rs1_data, 32'hAAAA5555);
        cmp("r0_z_cnt", 32'(bz.retire_count), 32'd2);
        cmp("r0_n_cnt", 32'(bn.retire_count), 32'd3);
        nextCycle();

        // Dual read of one register: bypassed value while writing, stored value otherwise.
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd7, 3'd2, 3'd2, 3'd2);
        settle();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd9, 3'd2, 3'd2, 3'd2);
        settle();
        cmp("dual_byp1", bz.rs1_data, 32'd9);
        cmp("dual_byp2", bz.rs2_data, 32'd9);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd9, 3'd2, 3'd2, 3'd2);
        settle();
        cmp("dual_old1", bz.rs1_data, 32'd7);
        cmp("dual_old2", bz.rs2_data, 32'd7);
        nextCycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom,
                          3'($urandom), 3'($urandom), 3'($urandom));
            settle();
            nextCycle();
        end

        // Asynchronous reset mid-cycle with the array preloaded.
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd3, 3'd5);
        settle();
        #1 rst = 1'b1;
        #1;
        cmp("arst_rs1", bz.rs1_data, 32'd0);
        cmp("arst_rs2", bz.rs2_data, 32'd0);
        cmp("arst_cnt_z", 32'(bz.retire_count), 32'd0);
        cmp("arst_cnt_n", 32'(bn.retire_count), 32'd0);
        clearModel();
        nextCycle();

        // A write presented while reset is held is bypassed but never committed.
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h5A5A1234, 3'd4, 3'd4, 3'd4);
        settle();
        cmp("rst_bypass", bz.rs1_data, 32'h5A5A1234);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd4, 3'd4, 3'd4);
        settle();
        cmp("rst_discard", bz.rs1_data, 32'd0);
        nextCycle();

        // 17 commits wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, $urandom, 3'd1, 3'd1, 3'd6);
            settle();
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd1, 3'd1, 3'd1);
        settle();
        cmp("wrap_n", 32'(bn.retire_count), 32'd1);
        cmp("wrap_z", 32'(bz.retire_count), 32'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
